multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 271 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: sequences fetch, decode, execute,
// memory access and writeback for lw/sw/R-type/addi/beq/bne/j, with a
// memory-wait timeout, a trap state for illegal opcodes and a retired-
// instruction counter.
//
// state  | code | meaning
// -------+------+-----------------------------------------------
// FETCH  |  0   | read instruction, PC+4 (waits on mem_ready)
// DECODE |  1   | latch opcode, compute branch target
// MEMADR |  2   | effective address for lw/sw
// MEMRD  |  3   | data read (waits on mem_ready)
// WBMEM  |  4   | write loaded data to rt
// MEMWR  |  5   | data write (waits on mem_ready)
// EXECR  |  6   | R-type ALU operation
// WBALU  |  7   | write ALU result (rd for R-type, rt for addi)
// EXECI  |  8   | addi ALU operation
// BRANCH |  9   | compare and conditionally load PC
// JUMP   | 10   | load jump target
// TRAP   | 11   | absorbing error state until reset
module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_source,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               timeout,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_WBMEM  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_WBALU  = 4'd7;
  localparam logic [3:0] S_EXECI  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // The wait counter only ever needs to reach TIMEOUT-1: the cycle on which
  // it would reach TIMEOUT is the cycle that traps.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [3:0]        r_state;
  logic [5:0]        r_op;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic              r_illegal;
  logic              r_timeout;

  logic [3:0]        w_next_state;
  logic              w_wait_state;
  logic              w_wait_expired;
  logic              w_set_illegal;
  logic              w_set_timeout;
  logic              w_retire;
  logic              w_fetch_done;

  assign w_wait_state   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_wait_expired = (TIMEOUT != 0) && w_wait_state && !mem_ready && (r_wait == WAIT_LAST);
  // Held low through reset so the reset-time outputs are the plain FETCH decode.
  assign w_fetch_done   = (r_state == S_FETCH) && mem_ready && rst_n;

  assign w_retire = (w_next_state == S_FETCH) &&
                    ((r_state == S_WBMEM) || (r_state == S_MEMWR) || (r_state == S_WBALU) ||
                     (r_state == S_BRANCH) || (r_state == S_JUMP));

  // Next-state selection, including illegal-opcode and memory-timeout traps.
  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   w_next_state = S_MEMADR;
          OP_RTYPE:       w_next_state = S_EXECR;
          OP_ADDI:        w_next_state = S_EXECI;
          OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
          OP_J:           w_next_state = S_JUMP;
          default: begin
            w_next_state  = S_TRAP;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next_state = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next_state = S_WBMEM;
      S_WBMEM:  w_next_state = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next_state = S_FETCH;
      S_EXECR:  w_next_state = S_WBALU;
      S_EXECI:  w_next_state = S_WBALU;
      S_WBALU:  w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      S_TRAP:   w_next_state = S_TRAP;
      default: begin
        w_next_state  = S_TRAP;
        w_set_illegal = 1'b1;
      end
    endcase
    if (w_wait_expired) begin
      w_next_state  = S_TRAP;
      w_set_timeout = 1'b1;
    end
  end

  // State register and opcode latch (captured while in DECODE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op    <= 6'b000000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end

  // Consecutive memory-wait cycle counter; any progress or state change clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if ((TIMEOUT == 0) || !w_wait_state || mem_ready || (w_next_state != r_state)) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Retired-instruction counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_retire)      r_retired <= r_retired + CNT_W'(1);
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  // Control strobes decoded from the current state and latched opcode.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = w_fetch_done;
        pc_write  = w_fetch_done;
        pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM4;
        alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WBMEM: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_WBALU: begin
        reg_write = 1'b1;
        reg_dst   = (r_op == OP_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_OUT;
        branch_ne     = (r_op == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: begin
      end
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-path model checked every
// cycle, plus directed sequences with literal expectations.
module tb_multicycle_control;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'b100011;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, branch_ne, ir_write, iord, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal, timeout;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  multicycle_control #(.ALUOP_W(3), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal(illegal), .timeout(timeout),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {pc_write, pc_write_cond, branch_ne, pc_source, ir_write, iord,
                     mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                     alu_src_b, alu_op};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Successor along the instruction's state path; 0 means the instruction completed,
  // -1 means the opcode has no path.
  function automatic int path_next(input int s, input logic [5:0] op);
    int p[5];
    int n;
    if (s == 0) return 1;
    case (op)
      6'b100011: begin p = '{0, 1, 2, 3, 4};  n = 5; end
      6'b101011: begin p = '{0, 1, 2, 5, 0};  n = 4; end
      6'b000000: begin p = '{0, 1, 6, 7, 0};  n = 4; end
      6'b001000: begin p = '{0, 1, 8, 7, 0};  n = 4; end
      6'b000100, 6'b000101: begin p = '{0, 1, 9, 0, 0}; n = 3; end
      6'b000010: begin p = '{0, 1, 10, 0, 0}; n = 3; end
      default: return -1;
    endcase
    for (int i = 1; i < n; i++)
      if (p[i] == s) return (i + 1 < n) ? p[i + 1] : 0;
    return -1;
  endfunction

  // Expected strobes, written per state straight from the control table.
  function automatic logic [17:0] exp_ctrl(input int s, input logic [5:0] op,
                                           input logic mr, input logic rn);
    logic pcw, pcwc, bne, irw, io, mrd, mwr, rw, rd, m2r, asa;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {pcw, pcwc, bne, irw, io, mrd, mwr, rw, rd, m2r, asa} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 3'd0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr & rn; pcw = mr & rn; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin asa = 1; aop = 3'd2; end
      7:  begin rw = 1; rd = (op == 6'b000000); end
      8:  begin asa = 1; asb = 2'b10; end
      9:  begin asa = 1; aop = 3'd1; pcwc = 1; pcs = 2'b01; bne = (op == 6'b000101); end
      10: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, bne, pcs, irw, io, mrd, mwr, rw, rd, m2r, asa, asb, aop};
  endfunction

  int          m_state = 0;
  logic [5:0]  m_op = '0;
  int          m_low = 0;
  logic [15:0] m_ret = '0;
  logic        m_ill = 1'b0;
  logic        m_to = 1'b0;

  // Reference model: walks instruction paths, holding in memory waits.
  always @(posedge clk or negedge rst_n) begin
    int prev, nxt;
    if (!rst_n) begin
      m_state = 0; m_op = '0; m_low = 0; m_ret = '0; m_ill = 1'b0; m_to = 1'b0;
    end else begin
      prev = m_state;
      if (m_state == 11) begin
      end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
        m_low++;
        if (m_low == TMO) begin m_state = 11; m_to = 1'b1; end
      end else begin
        if (m_state == 1) m_op = opcode;
        nxt = path_next(m_state, m_op);
        if (nxt < 0) begin m_state = 11; m_ill = 1'b1; end
        else begin
          if (nxt == 0) m_ret = m_ret + 16'd1;
          m_state = nxt;
        end
      end
      if (m_state != prev) m_low = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ctrl", {14'd0, dut_ctrl}, {14'd0, exp_ctrl(m_state, m_op, mem_ready, rst_n)});
      check("state", {28'd0, state}, m_state);
      check("illegal", {31'd0, illegal}, {31'd0, m_ill});
      check("timeout", {31'd0, timeout}, {31'd0, m_to});
      check("retired", {16'd0, retired}, {16'd0, m_ret});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic walk(input string nm, input int st[6], input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      check(nm, {28'd0, state}, st[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    step();
    step();
    cmp_en = 1'b1;
    check("rst_ctrl", {14'd0, dut_ctrl}, {14'd0, 18'b000_00_0_0_1_00000_01_000});
    check("rst_state", {28'd0, state}, 32'd0);
    rst_n = 1'b1;

    // lw with memory always ready
    walk("lw_path", '{0, 1, 2, 3, 4, 0}, 5);
    check("lw_reg_write", {31'd0, reg_write}, 32'd1);
    check("lw_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
    step();
    check("lw_end", {28'd0, state}, 32'd0);
    check("lw_retired", {16'd0, retired}, 32'd1);

    // bne
    opcode = 6'b000101;
    walk("bne_path", '{0, 1, 9, 0, 0, 0}, 3);
    check("bne_pcwc", {31'd0, pc_write_cond}, 32'd1);
    check("bne_ne", {31'd0, branch_ne}, 32'd1);
    check("bne_aluop", {29'd0, alu_op}, 32'd1);
    step();
    check("bne_end", {28'd0, state}, 32'd0);
    check("bne_retired", {16'd0, retired}, 32'd2);

    // sw with three wait cycles in MEMWR
    opcode = 6'b101011;
    walk("sw_path", '{0, 1, 2, 5, 0, 0}, 4);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sw_hold", {28'd0, state}, 32'd5);
      check("sw_mem_write", {31'd0, mem_write}, 32'd1);
    end
    mem_ready = 1'b1;
    step();
    check("sw_end", {28'd0, state}, 32'd0);
    check("sw_timeout", {31'd0, timeout}, 32'd0);
    check("sw_retired", {16'd0, retired}, 32'd3);

    // R-type, addi, j, beq
    opcode = 6'b000000;
    walk("r_path", '{0, 1, 6, 7, 0, 0}, 4);
    check("r_reg_dst", {31'd0, reg_dst}, 32'd1);
    step();
    opcode = 6'b001000;
    walk("addi_path", '{0, 1, 8, 7, 0, 0}, 4);
    check("addi_reg_dst", {31'd0, reg_dst}, 32'd0);
    step();
    opcode = 6'b000010;
    walk("j_path", '{0, 1, 10, 0, 0, 0}, 4);
    opcode = 6'b000100;
    walk("beq_path", '{0, 1, 9, 0, 0, 0}, 3);
    check("beq_ne", {31'd0, branch_ne}, 32'd0);
    step();
    check("mix_retired", {16'd0, retired}, 32'd7);

    // reset asserted while waiting in MEMRD
    opcode = 6'b100011;
    walk("lw2_path", '{0, 1, 2, 3, 0, 0}, 4);
    mem_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("async_state", {28'd0, state}, 32'd0);
    check("async_mem_read", {31'd0, mem_read}, 32'd1);
    check("async_iord", {31'd0, iord}, 32'd0);
    check("async_retired", {16'd0, retired}, 32'd0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // illegal opcode traps and sticks
    opcode = 6'b000010;
    walk("j2_path", '{0, 1, 10, 0, 0, 0}, 4);
    opcode = 6'b111111;
    walk("ill_path", '{0, 1, 11, 0, 0, 0}, 3);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_retired", {16'd0, retired}, 32'd1);
    repeat (3) step();
    check("ill_hold", {28'd0, state}, 32'd11);
    do_reset();
    check("ill_cleared", {31'd0, illegal}, 32'd0);

    // mem_ready arriving on the last allowed wait cycle wins
    opcode = 6'b000010;
    mem_ready = 1'b0;
    repeat (TMO - 1) step();
    check("edge_wait", {28'd0, state}, 32'd0);
    mem_ready = 1'b1;
    step();
    check("edge_decode", {28'd0, state}, 32'd1);
    check("edge_timeout", {31'd0, timeout}, 32'd0);
    step();
    step();

    // FETCH timeout
    mem_ready = 1'b0;
    repeat (TMO - 1) step();
    check("fto_wait", {28'd0, state}, 32'd0);
    step();
    check("fto_trap", {28'd0, state}, 32'd11);
    check("fto_flag", {31'd0, timeout}, 32'd1);
    mem_ready = 1'b1;
    repeat (3) step();
    check("fto_hold", {28'd0, state}, 32'd11);
    rst_n = 1'b0;
    #1;
    check("fto_reset", {31'd0, timeout}, 32'd0);
    step();
    rst_n = 1'b1;

    // MEMRD timeout
    opcode = 6'b100011;
    walk("lw3_path", '{0, 1, 2, 3, 0, 0}, 4);
    mem_ready = 1'b0;
    repeat (TMO) step();
    check("rto_trap", {28'd0, state}, 32'd11);
    check("rto_flag", {31'd0, timeout}, 32'd1);
    mem_ready = 1'b1;
    do_reset();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
